dds_sine_sched: RTL and testbench
=================================

# dds_sine_sched

Two-channel direct-digital-synthesis sequencer that shares one quarter-wave sine ROM (`quartsine`, 8-bit phase address, 11-bit offset-binary sample, midscale 1024) between several phase accumulators. On each sample tick it walks the enabled channels in index order. For each channel it issues that channel's phase MSBs to the ROM, waits for the ROM read latency, captures the sample, and advances the phase by the channel's tuning word. It sits between the sample-rate strobe generator and the per-channel sample consumers, such as DAC formatters.

## Interface
- `NCH`, 2: number of channels (1..4).
- `PHASE_W`, 16: phase accumulator width (≥ 8).
- `ROM_LAT`, 1: ROM read latency in clocks, from address change to valid `rom_data` (1..3).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clka` input 1: clock, rising edge.
- `resetn` input 1: asynchronous active-low reset.
- `tick` input 1: sample strobe, one-cycle pulse.
- `ch_en` input NCH: per-channel enable.
- `ftw` input NCH*PHASE_W: tuning words; channel c at `[c*PHASE_W +: PHASE_W]`.
- `rom_addr` output 8: to `quartsine.addra`; registered.
- `rom_data` input 11: from `quartsine.douta2`.
- `sample` output NCH*11: held samples; channel c at `[c*11 +: 11]`.
- `sample_valid` output NCH: one-cycle pulse per captured sample.
- `busy` output 1: frame in progress.
- `overrun` output 1: one-cycle pulse when a tick is dropped.

## Operation
- **Reset values:**
  - all phases 0;
  - `rom_addr` 0;
  - each `sample` 1024;
  - `sample_valid`, `busy`, `overrun` all 0;
  - FSM in IDLE.
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - A `tick` with `busy`=0 is accepted: latch `ch_en` into a mask and latch `ftw`.
  - If the mask is zero, stay in IDLE with no ROM activity.
  - Otherwise, select the lowest enabled channel and go to ISSUE.
- **ISSUE:**
  - `rom_addr` <= `phase[c][PHASE_W-1 -: 8]`.
  - Load the wait counter with `ROM_LAT`, then go to WAIT.
- **WAIT:**
  - Decrement the counter. When it expires, `sample[c]` <= `rom_data`, pulse `sample_valid[c]`, and set `phase[c]` <= `phase[c] + ftw[c]` mod 2^PHASE_W (wrap, no saturation).
  - On the same edge: if another enabled channel remains, drive the next channel's `rom_addr` directly (back-to-back issue); otherwise return to IDLE.
- **Read-then-advance:** the first sample after reset is read at phase 0.
- **Disabled channels:** phase, sample and `sample_valid` are untouched. A change to `ch_en` or `ftw` mid-frame has no effect until the next accepted tick.
- **Dropped ticks:** a `tick` while `busy`=1 is dropped. `overrun` pulses on the following cycle. No phase is advanced for the dropped tick.
- **Reset mid-frame:** asynchronous return to the reset values; the partial frame is discarded without `sample_valid`.

## Timing
- **Frame timing:** tick sampled at edge E0.
  - The first `rom_addr` is visible after E0.
  - Channel k (k-th enabled, from 0) is captured at edge E(k+1)*(ROM_LAT+1).
  - Its `sample_valid` is high for the cycle after that edge.
- **`rom_addr` hold:** stable for exactly ROM_LAT+1 cycles per channel.
- **`busy`:** rises after E0 and falls after the last capture edge. A tick coincident with the last capture edge is dropped.
- **Tick spacing:** minimum accepted period is M*(ROM_LAT+1)+1 cycles, where M is the number of enabled channels. Default with both channels enabled: 5.
- **Outputs:** all are registered; no combinational path from input to output.

## Structure
- **Package `dds_pkg`:**
  - `ROM_ADDR_W`=8;
  - `SAMPLE_W`=11;
  - `MIDSCALE`=11'd1024;
  - FSM state enum (IDLE/ISSUE/WAIT);
  - channel-index width function.
- **Sub-module `dds_phase_acc`:** one per channel via generate. It holds the phase register and performs the conditional add on an `adv` strobe.
- **Integration:** the ROM is not instantiated inside this block; the integration wrapper connects `rom_addr`/`rom_data` to `quartsine`.

## Test plan
- **Reset:** assert `resetn`=0 mid-run, then release. Required:
  - every `sample`=1024, `rom_addr`=0, `busy`/`sample_valid`/`overrun`=0;
  - next frame reads address 0x00 on all enabled channels.
- **Two channels:** `ch_en`=2'b11, ftw0=0x0100, ftw1=0x0400, 3 ticks at period 8. Required:
  - `rom_addr` sequence 0x00,0x00,0x01,0x04,0x02,0x08;
  - `sample_valid[0]` after E2, `sample_valid[1]` after E4;
  - samples equal the ROM model output.
- **Wrap-around:** ftw0=0xFF00, ch0 only. Required: addresses 0x00,0xFF,0xFE; phase wraps with no glitch in `sample_valid`.
- **Skipping:** `ch_en`=2'b10. Required:
  - only ch1 is read, captured at E2;
  - `busy` is high for 2 cycles;
  - `sample[0]` and phase0 are unchanged.
- **Overrun:** tick at E0 and again at E2, both channels enabled. Required:
  - `overrun` pulses once;
  - phases advance once;
  - next tick at E5 is accepted.
- **Reset mid-frame:** `resetn` low between E1 and E2. Required: no `sample_valid`; outputs at reset values; the next tick reads address 0x00.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants, FSM encoding and helpers for the two-channel DDS sequencer.
package dds_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam int SAMPLE_W   = 11;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 11'd1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } dds_state_e;

    function automatic int ch_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// One channel's phase accumulator: adds the tuning word on an adv strobe, wraps mod 2^PHASE_W.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv_i,
    input  logic [PHASE_W-1:0] ftw_i,
    output logic [PHASE_W-1:0] phase_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (adv_i) begin
            phase_d = phase_q + ftw_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/dds_sine_sched.sv
// Walks the enabled channels once per accepted tick, sharing one sine ROM:
// issue phase MSBs, wait ROM_LAT+1 cycles, capture the sample, advance the phase.
module dds_sine_sched
    import dds_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int PHASE_W = 16,
    parameter int ROM_LAT = 1
) (
    input  logic                    clka,
    input  logic                    resetn,
    input  logic                    tick,
    input  logic [NCH-1:0]          ch_en,
    input  logic [NCH*PHASE_W-1:0]  ftw,
    output logic [ROM_ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0]     rom_data,
    output logic [NCH*SAMPLE_W-1:0] sample,
    output logic [NCH-1:0]          sample_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int CW = ch_idx_w(NCH);
    localparam logic [1:0] CNT_INIT = 2'(ROM_LAT - 1);

    function automatic logic [CW-1:0] lowest(input logic [NCH-1:0] m);
        lowest = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest = CW'(i);
        end
    endfunction

    dds_state_e                         state_q, state_d;
    logic [NCH-1:0]                     mask_q, mask_d;
    logic [CW-1:0]                      cur_q, cur_d;
    logic [1:0]                         cnt_q, cnt_d;
    logic [NCH*PHASE_W-1:0]             ftw_q, ftw_d;
    logic [ROM_ADDR_W-1:0]              rom_addr_q, rom_addr_d;
    logic [NCH-1:0][SAMPLE_W-1:0]       sample_q, sample_d;
    logic [NCH-1:0]                     valid_q, valid_d;
    logic                               busy_q, busy_d;
    logic                               overrun_q, overrun_d;
    logic [NCH-1:0]                     adv;
    logic [NCH-1:0][PHASE_W-1:0]        phase;
    logic [CW-1:0]                      nxt;

    for (genvar g = 0; g < NCH; g++) begin : g_acc
        dds_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
            .clk    (clka),
            .rst_n  (resetn),
            .adv_i  (adv[g]),
            .ftw_i  (ftw_q[g*PHASE_W +: PHASE_W]),
            .phase_o(phase[g])
        );
    end

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        state_d    = state_q;
        mask_d     = mask_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        ftw_d      = ftw_q;
        rom_addr_d = rom_addr_q;
        sample_d   = sample_q;
        busy_d     = busy_q;
        valid_d    = '0;
        adv        = '0;
        nxt        = '0;
        overrun_d  = tick & busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    ftw_d = ftw;
                    if (ch_en != '0) begin
                        nxt        = lowest(ch_en);
                        cur_d      = nxt;
                        mask_d     = ch_en & ~(NCH'(1) << nxt);
                        rom_addr_d = phase[nxt][PHASE_W-1 -: ROM_ADDR_W];
                        busy_d     = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    sample_d[cur_q] = rom_data;
                    valid_d[cur_q]  = 1'b1;
                    adv[cur_q]      = 1'b1;
                    // Back-to-back: the next channel's address goes out on the capture edge.
                    if (mask_q != '0) begin
                        nxt        = lowest(mask_q);
                        cur_d      = nxt;
                        mask_d     = mask_q & ~(NCH'(1) << nxt);
                        rom_addr_d = phase[nxt][PHASE_W-1 -: ROM_ADDR_W];
                        state_d    = ST_ISSUE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            cur_q      <= '0;
            cnt_q      <= '0;
            ftw_q      <= '0;
            rom_addr_q <= '0;
            // NOTE: the sample holding registers are plain flops driven to midscale, not a memory.
            sample_q   <= {NCH{MIDSCALE}};
            valid_q    <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            ftw_q      <= ftw_d;
            rom_addr_q <= rom_addr_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_dds_sine_sched.sv
// Self-checking bench for dds_sine_sched: directed scenarios plus random frames
// checked cycle by cycle against a frame-level reference model.
module tb_dds_sine_sched;

    localparam int NCH     = 2;
    localparam int PHASE_W = 16;
    localparam int ROM_LAT = 1;
    localparam int L       = ROM_LAT + 1;

    logic        clka = 1'b0;
    logic        resetn;
    logic        tick;
    logic [1:0]  ch_en;
    logic [31:0] ftw;
    logic [7:0]  rom_addr;
    logic [10:0] rom_data = '0;
    logic [21:0] sample;
    logic [1:0]  sample_valid;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    logic [15:0] ph [2];
    logic [10:0] smp [2];
    logic [7:0]  last_addr;

    dds_sine_sched #(.NCH(NCH), .PHASE_W(PHASE_W), .ROM_LAT(ROM_LAT)) dut (
        .clka        (clka),
        .resetn      (resetn),
        .tick        (tick),
        .ch_en       (ch_en),
        .ftw         (ftw),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sample      (sample),
        .sample_valid(sample_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clka = ~clka;

    // Distinct value per address so any wrong address shows up in the captured sample.
    function automatic logic [10:0] rom_fn(input logic [7:0] a);
        return 11'(a) * 11'd7 + 11'd3;
    endfunction

    always @(posedge clka) rom_data <= rom_fn(rom_addr);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic model_reset();
        ph[0] = '0; ph[1] = '0;
        smp[0] = 11'd1024; smp[1] = 11'd1024;
        last_addr = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sample"},  sample, {11'd1024, 11'd1024});
        check({tag, "_addr"},    rom_addr, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_valid"},   sample_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_valid", sample_valid, 0);
            check("idle_overrun", overrun, 0);
            check("idle_addr", rom_addr, last_addr);
        end
    endtask

    // One accepted tick at the next edge (E0), then every cycle up to the one after
    // the last capture edge. drop_at>0 puts a second tick on edge E(drop_at).
    task automatic frame(input logic [1:0] en, input logic [15:0] f0,
                         input logic [15:0] f1, input int drop_at);
        int          chs[$];
        logic [7:0]  addrs[$];
        logic [15:0] fw[2];
        logic [1:0]  vexp;
        logic [7:0]  aexp;
        int          ml;
        fw[0] = f0; fw[1] = f1;
        for (int c = 0; c < 2; c++) begin
            if (en[c]) begin
                chs.push_back(c);
                addrs.push_back(ph[c][15:8]);
                ph[c] = ph[c] + fw[c];
            end
        end
        ml = chs.size() * L;

        ch_en = en; ftw = {f1, f0}; tick = 1'b1;
        step();
        ch_en = 2'($urandom);
        ftw   = $urandom;

        for (int t = 0; t <= ml; t++) begin
            vexp = '0;
            if (t > 0 && t % L == 0) begin
                vexp[chs[t/L-1]] = 1'b1;
                smp[chs[t/L-1]]  = rom_fn(addrs[t/L-1]);
            end
            if (t < ml)      aexp = addrs[t/L];
            else if (ml > 0) aexp = addrs[chs.size()-1];
            else             aexp = last_addr;
            check("rom_addr", rom_addr, aexp);
            check("busy", busy, (t < ml) ? 1 : 0);
            check("valid", sample_valid, vexp);
            check("sample", sample, {smp[1], smp[0]});
            check("overrun", overrun, (t == drop_at) ? 1 : 0);
            tick = (t == drop_at - 1);
            if (t < ml) step();
        end
        tick = 1'b0;
        if (ml > 0) last_addr = addrs[chs.size()-1];
    endtask

    initial begin
        int          nen, ml, drop;
        logic [1:0]  en;

        resetn = 1'b0; tick = 1'b0; ch_en = '0; ftw = '0;
        model_reset();
        step(); step();
        check_reset_values("por");
        resetn = 1'b1;
        idle(1);

        // Two channels, period 8: addresses 00,00,01,04,02,08.
        for (int i = 0; i < 3; i++) begin
            frame(2'b11, 16'h0100, 16'h0400, -1);
            idle(3);
        end

        // Reset asserted between E1 and E2 of a two-channel frame.
        ch_en = 2'b11; ftw = 32'h0400_0100; tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        resetn = 1'b0;
        #1;
        check_reset_values("rst_mid");
        step();
        check("rst_mid_novalid", sample_valid, 0);
        step();
        check_reset_values("rst_held");
        resetn = 1'b1;
        model_reset();
        idle(1);
        frame(2'b11, 16'h0000, 16'h0000, -1);
        idle(1);

        // Wrap-around on ch0: 00, FF, FE.
        for (int i = 0; i < 3; i++) frame(2'b01, 16'hFF00, 16'h1234, -1);
        idle(1);

        // Skipping ch0.
        frame(2'b10, 16'h5555, 16'h0C00, -1);
        idle(2);

        // Overrun: second tick on E2, next accepted tick on E5.
        frame(2'b11, 16'h0100, 16'h0400, 2);
        frame(2'b11, 16'h0100, 16'h0400, -1);
        // Tick coincident with the last capture edge is dropped.
        frame(2'b11, 16'h0080, 16'h0200, 4);
        idle(1);

        // Empty mask: accepted, no ROM activity.
        frame(2'b00, 16'h1111, 16'h2222, -1);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            en   = 2'($urandom_range(0, 3));
            nen  = int'(en[0]) + int'(en[1]);
            ml   = nen * L;
            drop = (ml > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, ml)) : -1;
            frame(en, 16'($urandom), 16'($urandom), drop);
            idle($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
